// File: rtl/div_unit_pkg.sv
// Shared definitions for the HI/LO multicycle units (divider now, multiplier later).
// Both units use the same start/done handshake and state encodings.
package div_unit_pkg;

   localparam int DIV_WIDTH = 32;

   localparam logic [1:0] DIV_IDLE = 2'd0;
   localparam logic [1:0] DIV_RUN  = 2'd1;
   localparam logic [1:0] DIV_FIX  = 2'd2;
   localparam logic [1:0] DIV_DONE = 2'd3;

   localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_unit_if.sv
// Start/done handshake and operand/result bus between the control unit and div_unit.
interface div_unit_if
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             done;
   logic             busy;
   logic             div_zero;

   modport master (
      output start, a_in, b_in,
      input  hi_out, lo_out, done, busy, div_zero
   );

   modport slave (
      input  start, a_in, b_in,
      output hi_out, lo_out, done, busy, div_zero
   );
endinterface

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: one quotient bit per cycle on magnitudes,
// signs applied in a final fix-up cycle. hi_out = remainder, lo_out = quotient.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic       clk,
   input  logic       reset,
   div_unit_if.slave  bus
);
   localparam int               CW         = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ZERO_QUOT  = WIDTH'(DIV_ZERO_QUOT);

   logic [1:0]       state_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] m_r;
   logic [WIDTH-1:0] r_r;
   logic [CW-1:0]    count_r;
   logic             sign_q_r;
   logic             sign_r_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic             done_r;
   logic             busy_r;
   logic             div_zero_r;

   logic [WIDTH:0]   r_sh_s;
   logic [WIDTH+1:0] diff_s;
   logic             fits_s;
   logic [WIDTH-1:0] r_next_s;
   logic [WIDTH-1:0] a_mag_s;
   logic [WIDTH-1:0] b_mag_s;
   logic             b_zero_s;

   // Trial subtraction and operand magnitudes (unsigned, so |MIN| stays exact)
   always_comb begin
      r_sh_s   = {r_r, q_r[WIDTH-1]};
      diff_s   = {1'b0, r_sh_s} - {2'b00, m_r};
      fits_s   = ~diff_s[WIDTH+1];
      r_next_s = r_sh_s[WIDTH-1:0];
      if (fits_s) begin
         r_next_s = diff_s[WIDTH-1:0];
      end else begin
         r_next_s = r_sh_s[WIDTH-1:0];
      end
      a_mag_s  = bus.a_in[WIDTH-1] ? (~bus.a_in + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.a_in;
      b_mag_s  = bus.b_in[WIDTH-1] ? (~bus.b_in + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.b_in;
      b_zero_s = (bus.b_in == {WIDTH{1'b0}});
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= DIV_IDLE;
         q_r        <= {WIDTH{1'b0}};
         m_r        <= {WIDTH{1'b0}};
         r_r        <= {WIDTH{1'b0}};
         count_r    <= {CW{1'b0}};
         sign_q_r   <= 1'b0;
         sign_r_r   <= 1'b0;
         hi_r       <= {WIDTH{1'b0}};
         lo_r       <= {WIDTH{1'b0}};
         done_r     <= 1'b0;
         busy_r     <= 1'b0;
         div_zero_r <= 1'b0;
      end else begin
         case (state_r)
            DIV_IDLE: begin
               done_r <= 1'b0;
               if (bus.start && b_zero_s) begin
                  hi_r       <= bus.a_in;
                  lo_r       <= ZERO_QUOT;
                  div_zero_r <= 1'b1;
                  done_r     <= 1'b1;
                  busy_r     <= 1'b1;
                  state_r    <= DIV_DONE;
               end else if (bus.start) begin
                  q_r        <= a_mag_s;
                  m_r        <= b_mag_s;
                  r_r        <= {WIDTH{1'b0}};
                  sign_q_r   <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
                  sign_r_r   <= bus.a_in[WIDTH-1];
                  count_r    <= {CW{1'b0}};
                  div_zero_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= DIV_RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= DIV_IDLE;
               end
            end
            DIV_RUN: begin
               r_r     <= r_next_s;
               q_r     <= {q_r[WIDTH-2:0], fits_s};
               count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
               if (count_r == LAST_COUNT) begin
                  state_r <= DIV_FIX;
               end else begin
                  state_r <= DIV_RUN;
               end
            end
            DIV_FIX: begin
               lo_r    <= sign_q_r ? (~q_r + {{(WIDTH-1){1'b0}}, 1'b1}) : q_r;
               hi_r    <= sign_r_r ? (~r_r + {{(WIDTH-1){1'b0}}, 1'b1}) : r_r;
               done_r  <= 1'b1;
               state_r <= DIV_DONE;
            end
            DIV_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= DIV_IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= DIV_IDLE;
            end
         endcase
      end
   end

   assign bus.hi_out   = hi_r;
   assign bus.lo_out   = lo_r;
   assign bus.done     = done_r;
   assign bus.busy     = busy_r;
   assign bus.div_zero = div_zero_r;

endmodule
